// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// fwd_hazard_ctrl: EX-stage operand forwarding selects and ID load-use stall.
// Optional macro FWD_HIST_EN adds a one-deep post-WB bypass (select 11).
// Revision: 1.0
// ============================================================================
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int LOAD_STALL  = 1,
  parameter int STALL_CNT_W = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_mem_reg_write,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic                  mem_wb_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  input  logic [REG_ADDR_W-1:0] id_ex_rs,
  input  logic [REG_ADDR_W-1:0] id_ex_rt,
  input  logic                  id_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] id_ex_rd,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  stall,
  output logic                  id_ex_flush
);

  if (LOAD_STALL < 1 || LOAD_STALL > (2 ** STALL_CNT_W) - 1) begin : g_bad_load_stall
    $error("fwd_hazard_ctrl: LOAD_STALL outside 1..2^STALL_CNT_W-1");
  end

  localparam logic [STALL_CNT_W-1:0] c_stall_init = STALL_CNT_W'(LOAD_STALL - 1);
  localparam logic [STALL_CNT_W-1:0] c_cnt_one    = STALL_CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_STALL = 1'b1
  } state_t;

  state_t                 r_state;
  logic [STALL_CNT_W-1:0] r_cnt;
  logic                   w_hz;
  logic                   w_hist_a;
  logic                   w_hist_b;

`ifdef FWD_HIST_EN
  logic                  r_hist_valid;
  logic [REG_ADDR_W-1:0] r_hist_rd;

  // Remembers the write-back that just retired so a consumer one slot later
  // can still take it before the regfile copy is readable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist_valid <= 1'b0;
      r_hist_rd    <= '0;
    end else begin
      r_hist_valid <= mem_wb_reg_write && (mem_wb_rd != '0);
      r_hist_rd    <= mem_wb_rd;
    end
  end

  assign w_hist_a = r_hist_valid && (r_hist_rd == id_ex_rs);
  assign w_hist_b = r_hist_valid && (r_hist_rd == id_ex_rt);
`else
  assign w_hist_a = 1'b0;
  assign w_hist_b = 1'b0;
`endif

  function automatic logic [1:0] sel_src(
    input logic [REG_ADDR_W-1:0] src,
    input logic                  hist_hit,
    input logic                  exm_we,
    input logic [REG_ADDR_W-1:0] exm_rd,
    input logic                  wb_we,
    input logic [REG_ADDR_W-1:0] wb_rd
  );
    if (exm_we && (exm_rd != '0) && (exm_rd == src))
      return 2'b10;
    else if (wb_we && (wb_rd != '0) && (wb_rd == src))
      return 2'b01;
    else if (hist_hit)
      return 2'b11;
    else
      return 2'b00;
  endfunction

  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (!rst) begin
      forward_a = sel_src(id_ex_rs, w_hist_a, ex_mem_reg_write, ex_mem_rd,
                          mem_wb_reg_write, mem_wb_rd);
      forward_b = sel_src(id_ex_rt, w_hist_b, ex_mem_reg_write, ex_mem_rd,
                          mem_wb_reg_write, mem_wb_rd);
    end
  end

  assign w_hz = id_ex_mem_read && (id_ex_rd != '0) &&
                ((id_ex_rd == id_rs) || (id_uses_rt && (id_ex_rd == id_rt)));

  // The first stall cycle is the IDLE cycle that sees the hazard; STALL
  // covers the remaining LOAD_STALL-1 cycles.
  assign stall       = !rst && ((r_state == S_STALL) || w_hz);
  assign id_ex_flush = stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hz && (LOAD_STALL > 1)) begin
            r_state <= S_STALL;
            r_cnt   <= c_stall_init;
          end
        end
        S_STALL: begin
          r_cnt <= r_cnt - c_cnt_one;
          if (r_cnt == c_cnt_one) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
Parametrised forwarding and hazard-control unit for the pipelined MIPS core. It generates the ALU operand-A/B source selects for the EX stage using newest-producer priority across the EX/MEM, MEM/WB and optional post-WB bypass stages. It also detects load-use hazards in ID and holds the front end for a configurable number of cycles while injecting bubbles into ID/EX. It sits beside the ID/EX register; its outputs drive the ALU source muxes, the PC/IF-ID write enables and the ID/EX flush.

Parameters:
REG_ADDR_W, 5, register address width; register 0 is hard-wired zero and is never forwarded.
LOAD_STALL, 1, stall cycles per load-use hazard; legal range 1..(2^STALL_CNT_W - 1).
STALL_CNT_W, 3, width of the internal stall counter.

Ports:
clk  in  1  core clock; all state updates on its rising edge.
rst  in  1  synchronous active-high reset.
ex_mem_reg_write  in  1  EX/MEM stage writes a register.
ex_mem_rd  in  REG_ADDR_W  EX/MEM destination register.
mem_wb_reg_write  in  1  MEM/WB stage writes a register.
mem_wb_rd  in  REG_ADDR_W  MEM/WB destination register.
id_ex_rs  in  REG_ADDR_W  EX-stage source A register.
id_ex_rt  in  REG_ADDR_W  EX-stage source B register.
id_ex_mem_read  in  1  EX-stage instruction is a load.
id_ex_rd  in  REG_ADDR_W  EX-stage load destination register.
id_rs  in  REG_ADDR_W  ID-stage source A register.
id_rt  in  REG_ADDR_W  ID-stage source B register.
id_uses_rt  in  1  ID-stage instruction reads rt (0 for I-type ALU ops, jumps).
forward_a  out  2  ALU-A select: 00 regfile, 01 MEM/WB, 10 EX/MEM, 11 post-WB bypass.
forward_b  out  2  ALU-B select, same encoding.
stall  out  1  hold PC and IF/ID (active high).
id_ex_flush  out  1  zero ID/EX control bits (insert bubble).

Behaviour:
- Reset: rst is sampled on the clk edge only. While rst=1: forward_a=forward_b=00, stall=0, id_ex_flush=0. On the next edge: FSM goes to IDLE, counter=0, hist_valid=0, hist_rd=0. Reset in mid-stall aborts the stall; stall=0 in the cycle after the reset edge.
- Forwarding is combinational from the current inputs plus the hist registers. Priority is newest first, per operand (shown for A; B is identical using id_ex_rt):
  - 10 if ex_mem_reg_write and ex_mem_rd!=0 and ex_mem_rd==id_ex_rs.
  - Else 01 if mem_wb_reg_write and mem_wb_rd!=0 and mem_wb_rd==id_ex_rs.
  - Else 11 if hist_valid and hist_rd==id_ex_rs (FWD_HIST_EN only).
  - Else 00.
- Hazard detect (combinational): hz = id_ex_mem_read and id_ex_rd!=0 and (id_ex_rd==id_rs or (id_uses_rt and id_ex_rd==id_rt)).
- FSM, states IDLE and STALL:
  - IDLE: stall=id_ex_flush=hz. If hz and LOAD_STALL>1, go to STALL with cnt=LOAD_STALL-1. If hz and LOAD_STALL==1, remain in IDLE.
  - STALL: stall=1, id_ex_flush=1, hz is ignored. Each edge decrements cnt. On the edge where cnt==1, go to IDLE.
  - Net result: exactly LOAD_STALL consecutive stall cycles per hazard. A second hazard can be recognised no earlier than the first IDLE cycle after the stall.
- Forwarding stays active during stall cycles. Selects follow the inputs regardless of FSM state.
- Counter is never below 0 and never wraps. A LOAD_STALL value outside the legal range is a parameter error and must fail elaboration.

Optional Feature:
FWD_HIST_EN.
- Defined: adds a one-deep post-WB history. Every edge (rst=0) loads hist_valid<=mem_wb_reg_write and (mem_wb_rd!=0), and hist_rd<=mem_wb_rd. Select 11 may then be produced; the datapath supplies the matching registered write-back value.
- Undefined: no hist registers are built and select 11 is never produced. The regfile must write in the first half-cycle and read in the second.

Test Plan:
- EX/MEM rd=3 write=1, MEM/WB rd=3 write=1, id_ex_rs=3, id_ex_rt=3 -> forward_a=10, forward_b=10 (newest wins).
- EX/MEM rd=0 write=1, MEM/WB rd=0 write=1, id_ex_rs=0 -> forward_a=00; then MEM/WB rd=4 write=1, id_ex_rt=4, EX/MEM write=0 -> forward_b=01.
- LOAD_STALL=1: id_ex_mem_read=1, id_ex_rd=5, id_rs=5 -> stall=1 and id_ex_flush=1 for exactly 1 cycle; id_uses_rt=0 with id_rt=5, id_rs=6 -> stall=0.
- LOAD_STALL=3: same hazard -> stall high for 3 consecutive cycles, then 0. Repeat with rst=1 at stall cycle 2 -> stall=0 from the cycle after the reset edge, and the FSM is in IDLE.
- FWD_HIST_EN defined: MEM/WB rd=7 write=1 at cycle n; at n+1 id_ex_rt=7 with no EX/MEM or MEM/WB match -> forward_b=11. Same stimulus without the macro -> forward_b=00.
